// File: rtl/run_control_harness.sv
// Run controller for the single-cycle core: streams a program into instruction
// memory, releases the core, then stops on a PC self-loop or a cycle budget.
module run_control_harness #(
   parameter int XLEN        = 32,
   parameter int IMEM_DEPTH  = 64,
   parameter int MAX_CYCLES  = 1024,
   parameter int HALT_REPEAT = 2,
   localparam int AW = $clog2(IMEM_DEPTH),
   localparam int CW = $clog2(MAX_CYCLES + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   output logic            load_ready,
   input  logic [XLEN-1:0] load_data,
   input  logic            load_last,
   output logic            imem_we,
   output logic [AW-1:0]   imem_waddr,
   output logic [XLEN-1:0] imem_wdata,
   output logic            core_rst,
   input  logic [XLEN-1:0] core_pc,
   output logic            done,
   output logic            halted,
   output logic            timeout,
   output logic            load_overflow,
   output logic [CW-1:0]   cycle_count,
   output logic [XLEN-1:0] halt_pc
);

   localparam int SW = $clog2(HALT_REPEAT + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);
   localparam logic [CW-1:0] MAX_C     = CW'(MAX_CYCLES);
   localparam logic [SW-1:0] HR        = SW'(HALT_REPEAT);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [AW-1:0]   addr_q, addr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic [SW-1:0]   same_cnt_q, same_cnt_d;
   logic [CW-1:0]   cycle_count_q, cycle_count_d;
   logic            done_q, done_d;
   logic            halted_q, halted_d;
   logic            timeout_q, timeout_d;
   logic            overflow_q, overflow_d;
   logic [XLEN-1:0] halt_pc_q, halt_pc_d;

   logic accept_s;
   logic last_addr_s;
   logic pc_match_s;
   logic halt_hit_s;
   logic timeout_hit_s;

   assign accept_s      = load_valid && (state_q == ST_LOAD);
   assign last_addr_s   = (addr_q == LAST_ADDR);
   assign pc_match_s    = pc_valid_q && (core_pc == pc_q);
   assign halt_hit_s    = pc_match_s && ((same_cnt_q + SW'(1)) == HR);
   assign timeout_hit_s = (cycle_count_q == (MAX_C - CW'(1)));

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: begin
            if (accept_s && (load_last || last_addr_s)) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (halt_hit_s || timeout_hit_s) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_LOAD;
      endcase
   end

   // State-decoded outputs toward loader, memory and core
   always_comb begin
      load_ready = 1'b0;
      core_rst   = 1'b0;
      imem_waddr = addr_q;
      imem_wdata = load_data;
      case (state_q)
         ST_LOAD: load_ready = 1'b1;
         ST_RUN:  core_rst   = 1'b1;
         ST_DONE: core_rst   = 1'b0;
         default: load_ready = 1'b0;
      endcase
      imem_we = load_valid && load_ready;
   end

   // Datapath next-state: load address, PC tracking, counters and status
   always_comb begin
      addr_d        = addr_q;
      pc_d          = pc_q;
      pc_valid_d    = pc_valid_q;
      same_cnt_d    = same_cnt_q;
      cycle_count_d = cycle_count_q;
      done_d        = done_q;
      halted_d      = halted_q;
      timeout_d     = timeout_q;
      overflow_d    = overflow_q;
      halt_pc_d     = halt_pc_q;
      case (state_q)
         ST_LOAD: begin
            if (accept_s) begin
               // Address saturates at the top word so it never wraps to 0
               if (!last_addr_s) begin
                  addr_d = addr_q + AW'(1);
               end else begin
                  overflow_d = !load_last;
               end
            end else begin
               addr_d = addr_q;
            end
         end
         ST_RUN: begin
            if (cycle_count_q != MAX_C) begin
               cycle_count_d = cycle_count_q + CW'(1);
            end else begin
               cycle_count_d = cycle_count_q;
            end
            pc_d       = core_pc;
            pc_valid_d = 1'b1;
            if (pc_match_s) begin
               same_cnt_d = same_cnt_q + SW'(1);
            end else begin
               same_cnt_d = '0;
            end
            // Halt wins over a timeout landing on the same edge
            if (halt_hit_s) begin
               done_d    = 1'b1;
               halted_d  = 1'b1;
               halt_pc_d = core_pc;
            end else if (timeout_hit_s) begin
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               done_d    = 1'b0;
            end
         end
         ST_DONE: done_d = 1'b1;
         default: done_d = done_q;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q        <= '0;
         pc_q          <= '0;
         pc_valid_q    <= 1'b0;
         same_cnt_q    <= '0;
         cycle_count_q <= '0;
         done_q        <= 1'b0;
         halted_q      <= 1'b0;
         timeout_q     <= 1'b0;
         overflow_q    <= 1'b0;
         halt_pc_q     <= '0;
      end else begin
         addr_q        <= addr_d;
         pc_q          <= pc_d;
         pc_valid_q    <= pc_valid_d;
         same_cnt_q    <= same_cnt_d;
         cycle_count_q <= cycle_count_d;
         done_q        <= done_d;
         halted_q      <= halted_d;
         timeout_q     <= timeout_d;
         overflow_q    <= overflow_d;
         halt_pc_q     <= halt_pc_d;
      end
   end

   assign done          = done_q;
   assign halted        = halted_q;
   assign timeout       = timeout_q;
   assign load_overflow = overflow_q;
   assign cycle_count   = cycle_count_q;
   assign halt_pc       = halt_pc_q;

endmodule

// File: tb/tb_run_control_harness.sv
// Directed bench for run_control_harness: memory writes are checked against a
// scoreboard queue, run status against hand-derived constants.
module tb_run_control_harness;

   localparam int XLEN = 32;
   localparam int DEPTH = 8;
   localparam int MAXC = 16;
   localparam int AW = 3;
   localparam int CW = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load_valid = 1'b0;
   logic            load_ready;
   logic [XLEN-1:0] load_data = '0;
   logic            load_last = 1'b0;
   logic            imem_we;
   logic [AW-1:0]   imem_waddr;
   logic [XLEN-1:0] imem_wdata;
   logic            core_rst;
   logic [XLEN-1:0] core_pc = '0;
   logic            done;
   logic            halted;
   logic            timeout;
   logic            load_overflow;
   logic [CW-1:0]   cycle_count;
   logic [XLEN-1:0] halt_pc;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int wr_base = 0;
   logic [AW+XLEN-1:0] exp_q[$];
   logic [AW+XLEN-1:0] exp_w;

   run_control_harness #(
      .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_REPEAT(2)
   ) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_last(load_last),
      .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
      .core_rst(core_rst), .core_pc(core_pc),
      .done(done), .halted(halted), .timeout(timeout),
      .load_overflow(load_overflow), .cycle_count(cycle_count), .halt_pc(halt_pc)
   );

   always #5 clk = ~clk;

   // Every memory write must match the oldest word pushed by the stimulus
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_cnt++;
         total++;
         assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL wr_spurious observed addr=%0h data=%0h expected no write", imem_waddr, imem_wdata);
         end
         if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            assert ({imem_waddr, imem_wdata} === exp_w) else begin
               bad++;
               $error("FAIL wr_word observed=%0h expected=%0h", {imem_waddr, imem_wdata}, exp_w);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ready"}, 64'(load_ready), 64'd1);
      chk({tag, "_core_rst"}, 64'(core_rst), 64'd0);
      chk({tag, "_we"}, 64'(imem_we), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_halted"}, 64'(halted), 64'd0);
      chk({tag, "_timeout"}, 64'(timeout), 64'd0);
      chk({tag, "_ovf"}, 64'(load_overflow), 64'd0);
      chk({tag, "_cc"}, 64'(cycle_count), 64'd0);
      chk({tag, "_hpc"}, 64'(halt_pc), 64'd0);
   endtask

   task automatic send(input int addr, input logic [XLEN-1:0] data, input logic last);
      load_valid = 1'b1;
      load_data  = data;
      load_last  = last;
      exp_q.push_back({AW'(addr), data});
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic do_reset();
      load_valid = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      logic [XLEN-1:0] pcs [5];
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8; pcs[3] = 32'h8; pcs[4] = 32'h8;

      // Reset state
      tick();
      tick();
      chk_reset("rst0");
      rst = 1'b1;

      // Four-word program, last word carries load_last
      for (int i = 0; i < 4; i++) begin
         send(i, (i == 3) ? 32'h0000006F : 32'h00000013, (i == 3));
      end
      chk("load4_writes", 64'(wr_cnt), 64'd4);
      chk("load4_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("load4_ready", 64'(load_ready), 64'd0);
      chk("load4_core_rst", 64'(core_rst), 64'd1);
      chk("load4_ovf", 64'(load_overflow), 64'd0);

      // Halt: PC 0,4,8,8,8 while the host keeps offering words (must be ignored)
      load_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         core_pc = pcs[i];
         if (i == 4) chk("halt_not_early", 64'(done), 64'd0);
         tick();
      end
      chk("halt_done", 64'(done), 64'd1);
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_timeout", 64'(timeout), 64'd0);
      chk("halt_pc", 64'(halt_pc), 64'h8);
      chk("halt_cc", 64'(cycle_count), 64'd5);
      chk("halt_core_rst", 64'(core_rst), 64'd0);
      for (int i = 0; i < 3; i++) begin
         core_pc = 32'h40 + 32'(i);
         tick();
      end
      chk("done_hold_cc", 64'(cycle_count), 64'd5);
      chk("done_hold_pc", 64'(halt_pc), 64'h8);
      chk("done_no_writes", 64'(wr_cnt), 64'd4);

      // Gap in load_valid: 1,0,1 gives exactly two writes
      do_reset();
      chk_reset("rst1");
      wr_base = wr_cnt;
      send(0, 32'hAAAA0001, 1'b0);
      tick();
      chk("gap_ready", 64'(load_ready), 64'd1);
      send(1, 32'hAAAA0002, 1'b1);
      chk("gap_writes", 64'(wr_cnt - wr_base), 64'd2);
      chk("gap_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("gap_core_rst", 64'(core_rst), 64'd1);

      // Timeout: PC advances every cycle
      for (int i = 0; i < MAXC; i++) begin
         core_pc = 32'h100 + 32'(4 * i);
         if (i == MAXC - 1) chk("to_not_early", 64'(done), 64'd0);
         tick();
      end
      chk("to_timeout", 64'(timeout), 64'd1);
      chk("to_done", 64'(done), 64'd1);
      chk("to_halted", 64'(halted), 64'd0);
      chk("to_cc", 64'(cycle_count), 64'd16);
      chk("to_core_rst", 64'(core_rst), 64'd0);
      tick();
      tick();
      chk("to_cc_hold", 64'(cycle_count), 64'd16);

      // load_last on the top address: no overflow
      do_reset();
      wr_base = wr_cnt;
      for (int i = 0; i < DEPTH; i++) begin
         send(i, 32'hB0000000 + 32'(i), (i == DEPTH - 1));
      end
      chk("full_writes", 64'(wr_cnt - wr_base), 64'd8);
      chk("full_ovf", 64'(load_overflow), 64'd0);
      chk("full_core_rst", 64'(core_rst), 64'd1);

      // Overflow: ten words without load_last, only eight accepted
      do_reset();
      wr_base = wr_cnt;
      for (int i = 0; i < 10; i++) begin
         load_valid = 1'b1;
         load_data  = 32'hC0DE0000 + 32'(i);
         load_last  = 1'b0;
         core_pc    = 32'(4 * i);
         if (i < DEPTH) exp_q.push_back({AW'(i), load_data});
         else chk("ovf_ready_low", 64'(load_ready), 64'd0);
         tick();
      end
      load_valid = 1'b0;
      chk("ovf_writes", 64'(wr_cnt - wr_base), 64'd8);
      chk("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("ovf_flag", 64'(load_overflow), 64'd1);
      chk("ovf_core_rst", 64'(core_rst), 64'd1);
      chk("ovf_cc", 64'(cycle_count), 64'd2);

      // Reset mid-run at cycle_count 7, then reload from address 0
      for (int i = 0; i < 5; i++) begin
         core_pc = 32'h200 + 32'(4 * i);
         tick();
      end
      chk("mid_cc7", 64'(cycle_count), 64'd7);
      do_reset();
      chk_reset("rst_mid");
      send(0, 32'hD0000000, 1'b0);
      send(1, 32'hD0000001, 1'b1);
      chk("reload_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("reload_core_rst", 64'(core_rst), 64'd1);
      chk("reload_ovf", 64'(load_overflow), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/run_control_harness.md
# run_control_harness

Parametrised, synthesizable run controller that sits between a host loader and the single-cycle RISC-V core top. It streams a program into instruction memory over a valid/ready handshake. It then releases the core's reset and counts executed cycles. It stops the run when the core halts (PC self-loop) or a cycle budget expires, and reports status, cycle count and halt PC.

## Interface
Parameters:
- XLEN, 32, data/PC width
- IMEM_DEPTH, 64, instruction memory depth in words (≥2, power of two)
- MAX_CYCLES, 1024, run-cycle budget before timeout (≥2)
- HALT_REPEAT, 2, consecutive cycles with unchanged PC that declare a halt (≥1)

Ports (AW = $clog2(IMEM_DEPTH), CW = $clog2(MAX_CYCLES+1)):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset; synchronous, active-low
- load_valid  in  1  host word available
- load_ready  out  1  controller accepts word
- load_data  in  XLEN  program word
- load_last  in  1  marks final program word
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  AW  word address
- imem_wdata  out  XLEN  word to write
- core_rst  out  1  core reset, active-low (0 holds core in reset)
- core_pc  in  XLEN  core's current PC
- done  out  1  run finished (sticky)
- halted  out  1  finished by PC self-loop
- timeout  out  1  finished by cycle budget
- load_overflow  out  1  memory filled before load_last
- cycle_count  out  CW  run cycles elapsed
- halt_pc  out  XLEN  PC at halt detection

## Operation
- States: LOAD (reset state) → RUN → DONE; DONE exits only via rst.
- LOAD: load_ready=1, core_rst=0. imem_we = load_valid & load_ready (combinational); imem_waddr = addr_q; imem_wdata = load_data. On each accepted word addr_q increments.
  - Accepted word with load_last=1 → RUN.
  - Accepted word at addr_q=IMEM_DEPTH-1 with load_last=0 → RUN, load_overflow set (sticky). No wrap: address never returns to 0.
  - Accepted word with load_last=1 at addr_q=IMEM_DEPTH-1 → RUN, no overflow.
- RUN: load_ready=0, imem_we=0, core_rst=1. cycle_count increments every edge.
  - pc_q registers core_pc each edge; pc_valid set after first RUN edge.
  - same_cnt: increments when pc_valid and core_pc==pc_q, else clears to 0.
  - Halt: edge on which same_cnt would reach HALT_REPEAT → DONE, halted=1, halt_pc=core_pc.
  - Timeout: edge on which cycle_count goes from MAX_CYCLES-1 to MAX_CYCLES → DONE, timeout=1.
  - Simultaneous halt and timeout on the same edge: halted=1, timeout=0, halt_pc captured. cycle_count still reaches MAX_CYCLES.
- DONE: core_rst=0 (core frozen), load_ready=0, done=1. cycle_count, halt_pc and the flags are held.
- cycle_count saturates; never wraps.

## Timing
- Reset (rst=0 at an edge): state=LOAD, addr_q=0, load_ready=1, core_rst=0, imem_we=0 (absent load_valid), done=halted=timeout=load_overflow=0, cycle_count=0, halt_pc=0, pc_q=0, pc_valid=0, same_cnt=0.
- Reset mid-LOAD, mid-RUN or in DONE: same values next cycle. Partially loaded memory contents are not cleared.
- load_valid held with load_ready=0 (post-LOAD): ignored, no writes.
- Write latency: the word is written on the edge where valid&ready; the RUN transition occurs on that same edge.
- First RUN cycle: core_rst=1; the core sees reset released at the following edge.
- Halt latency: a PC constant from cycle t is detected at the edge ending cycle t+HALT_REPEAT; done=1 from then on.
- All outputs are registered except load_ready, imem_we, imem_waddr, imem_wdata and core_rst, which decode state.

## Test plan
- Load 4 words (0x00000013 ×3, last 0x0000006F with load_last): imem_waddr 0..3 with imem_we each; RUN next cycle, core_rst=1, load_overflow=0.
- Backpressure/gaps: load_valid toggled 1,0,1 → exactly 2 writes at addresses 0 and 1, no spurious imem_we.
- Halt: core_pc 0,4,8,8,8 with HALT_REPEAT=2 → done=halted=1 at edge after the third 8; halt_pc=8, cycle_count=5, core_rst=0.
- Timeout: MAX_CYCLES=16, PC increments by 4 every cycle → timeout=1, done=1, cycle_count=16, halted=0.
- Overflow: IMEM_DEPTH=8, 10 words sent without load_last → 8 writes (addr 0..7), load_overflow=1, words 9–10 not accepted, RUN entered.
- Reset mid-RUN at cycle_count=7 → all outputs return to reset values, load_ready=1; a reload of 2 words restarts at address 0.
